// File: rtl/spi_ram_burst_if.sv
// Command/response bus between the SPI slave shifter, the RAM block and the tx serialiser.
interface spi_ram_burst_if #(
    parameter int DATA_W = 8
);
    logic [DATA_W+1:0] din;
    logic              rx_valid;
    logic [DATA_W-1:0] dout;
    logic              tx_valid;
    logic              tx_ready;
    logic              overrun;
    logic              clr_ovr;

    modport master (
        output din, rx_valid, tx_ready, clr_ovr,
        input  dout, tx_valid, overrun
    );

    modport slave (
        input  din, rx_valid, tx_ready, clr_ovr,
        output dout, tx_valid, overrun
    );
endinterface

// File: rtl/spi_ram_burst.sv
// Single-port RAM driven by 2-bit opcode commands from the SPI slave, with optional burst
// auto-increment, a valid/ready read-data handshake and a sticky read-overrun flag.
module spi_ram_burst #(
    parameter int DATA_W         = 8,
    parameter int ADDR_W         = 8,
    parameter int AUTO_INC       = 1,
    parameter int CLEAR_ON_RESET = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    spi_ram_burst_if.slave    bus
);

    localparam int DEPTH = 1 << ADDR_W;

    localparam logic [1:0] OP_SET_WA = 2'b00;
    localparam logic [1:0] OP_WRITE  = 2'b01;
    localparam logic [1:0] OP_SET_RA = 2'b10;
    localparam logic [1:0] OP_READ   = 2'b11;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [ADDR_W-1:0] addr_wr;
    logic [ADDR_W-1:0] addr_rd;
    logic [DATA_W-1:0] dout_p1;
    logic              vld_p1;
    logic              ovr;

    logic [1:0]        op;
    logic [DATA_W-1:0] payload;
    logic              cmd_vld;
    logic              wr_en;
    logic              rd_req;
    logic              rd_accept;
    logic              rd_drop;
    logic              xfer;

    // Address increment wraps silently modulo the RAM depth.
    function automatic logic [ADDR_W-1:0] addr_next(input logic [ADDR_W-1:0] a);
        return a + ADDR_W'(1);
    endfunction

    assign op      = bus.din[DATA_W+1:DATA_W];
    assign payload = bus.din[DATA_W-1:0];

    // Command decode; a read is accepted only if the output slot is free or being drained now.
    always_comb begin
        cmd_vld   = rst_n & bus.rx_valid;
        wr_en     = cmd_vld && (op == OP_WRITE);
        rd_req    = cmd_vld && (op == OP_READ);
        xfer      = vld_p1 & bus.tx_ready;
        rd_accept = rd_req && (!vld_p1 || bus.tx_ready);
        rd_drop   = rd_req && !rd_accept;
    end

    // Write-address register: loaded by op00, optionally post-incremented by each write.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_wr <= '0;
        end else if (cmd_vld && (op == OP_SET_WA)) begin
            addr_wr <= payload[ADDR_W-1:0];
        end else if (wr_en && (AUTO_INC != 0)) begin
            addr_wr <= addr_next(addr_wr);
        end
    end

    // Read-address register: loaded by op10, optionally post-incremented by each accepted read.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_rd <= '0;
        end else if (cmd_vld && (op == OP_SET_RA)) begin
            addr_rd <= payload[ADDR_W-1:0];
        end else if (rd_accept && (AUTO_INC != 0)) begin
            addr_rd <= addr_next(addr_rd);
        end
    end

    generate
        if (CLEAR_ON_RESET != 0) begin : g_mem_clr
            // Memory array with every word cleared while reset is asserted.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    for (int i = 0; i < DEPTH; i++) begin
                        mem[i] <= '0;
                    end
                end else if (wr_en) begin
                    mem[addr_wr] <= payload;
                end
            end
        end else begin : g_mem_keep
            // Memory array that keeps its contents across reset.
            always_ff @(posedge clk) begin
                if (wr_en) begin
                    mem[addr_wr] <= payload;
                end
            end
        end
    endgenerate

    // ---- read stage p1: registered read data and its valid, held until transferred ----
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dout_p1 <= '0;
            vld_p1  <= 1'b0;
        end else if (rd_accept) begin
            dout_p1 <= mem[addr_rd];
            vld_p1  <= 1'b1;
        end else if (xfer) begin
            vld_p1  <= 1'b0;
        end
    end

    // Sticky overrun: a dropped read sets it, clr_ovr clears it, set has priority.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovr <= 1'b0;
        end else if (rd_drop) begin
            ovr <= 1'b1;
        end else if (bus.clr_ovr) begin
            ovr <= 1'b0;
        end
    end

    assign bus.dout     = dout_p1;
    assign bus.tx_valid = vld_p1;
    assign bus.overrun  = ovr;

endmodule
